// File: rtl/fetch_queue.sv
// Instruction-byte queue between ICache and Decoder: line fills packed into a circular buffer,
// 15-byte decode window out. Optional counters enabled by FETCH_QUEUE_STATS_EN.
module fetch_queue #(
  parameter int BUF_BYTES  = 128,
  parameter int LINE_BYTES = 64,
  parameter int WIN_BYTES  = 15
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [63:0]             entry,
  input  logic                    redirect_valid,
  input  logic [63:0]             redirect_rip,
  output logic                    ic_req,
  output logic [63:0]             ic_addr,
  input  logic [LINE_BYTES*8-1:0] ic_rdata,
  input  logic                    ic_done,
  output logic                    dec_valid,
  output logic [WIN_BYTES*8-1:0]  dec_bytes,
  output logic [63:0]             dec_rip,
  input  logic [3:0]              dec_consume,
  output logic [31:0]             stat_lines,
  output logic [31:0]             stat_starve
);

  localparam int PTR_W = $clog2(BUF_BYTES);
  localparam int OCC_W = PTR_W + 1;
  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam logic [63:0] LINE_MASK = ~64'(LINE_BYTES - 1);

  typedef enum logic [1:0] {START, IDLE, WAIT, DROP} state_t;

  state_t           state;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [OCC_W-1:0] occupancy;
  logic [63:0]      fetch_line;
  logic [OFF_W-1:0] skip;
  logic [7:0]       buffer [BUF_BYTES];

  logic             fill_accept;
  logic [OCC_W-1:0] fill_len;
  logic [OCC_W-1:0] consume_len;
  logic             room_for_line;

  // Redirect wins over both the fill and the consume of its cycle.
  assign fill_accept   = (state == WAIT) && ic_done && !redirect_valid;
  assign fill_len      = fill_accept ? OCC_W'(LINE_BYTES) - OCC_W'(skip) : '0;
  assign consume_len   = OCC_W'(dec_consume);
  assign room_for_line = occupancy <= OCC_W'(BUF_BYTES - LINE_BYTES);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= START;
      ic_req     <= 1'b0;
      ic_addr    <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      occupancy  <= '0;
      dec_rip    <= '0;
      fetch_line <= '0;
      skip       <= '0;
    end else if (redirect_valid) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      occupancy  <= '0;
      dec_rip    <= redirect_rip;
      fetch_line <= redirect_rip & LINE_MASK;
      skip       <= redirect_rip[OFF_W-1:0];
      // An outstanding request must still be retired by the ICache, so keep it and drop its data.
      if ((state == WAIT || state == DROP) && !ic_done) begin
        state <= DROP;
      end else begin
        state   <= IDLE;
        ic_req  <= 1'b0;
        ic_addr <= '0;
      end
    end else begin
      rd_ptr    <= rd_ptr + PTR_W'(dec_consume);
      dec_rip   <= dec_rip + 64'(dec_consume);
      wr_ptr    <= wr_ptr + PTR_W'(fill_len);
      occupancy <= occupancy + fill_len - consume_len;
      unique case (state)
        START: begin
          state      <= IDLE;
          fetch_line <= entry & LINE_MASK;
          skip       <= entry[OFF_W-1:0];
          dec_rip    <= entry;
        end
        IDLE: begin
          if (room_for_line) begin
            ic_req  <= 1'b1;
            ic_addr <= fetch_line;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (ic_done) begin
            fetch_line <= fetch_line + 64'(LINE_BYTES);
            skip       <= '0;
            ic_req     <= 1'b0;
            ic_addr    <= '0;
            state      <= IDLE;
          end
        end
        DROP: begin
          if (ic_done) begin
            ic_req  <= 1'b0;
            ic_addr <= '0;
            state   <= IDLE;
          end
        end
        default: state <= START;
      endcase
    end
  end

  // NOTE: the byte store has no reset; its contents are never read before a fill covers them.
  always_ff @(posedge clk) begin
    if (fill_accept) begin
      for (int i = 0; i < LINE_BYTES; i++) begin
        if (i >= int'(skip)) begin
          buffer[wr_ptr + PTR_W'(i) - PTR_W'(skip)] <= ic_rdata[i*8 +: 8];
        end
      end
    end
  end

  // NOTE: default assignment first keeps this block free of inferred latches.
  always_comb begin
    dec_bytes = '0;
    for (int k = 0; k < WIN_BYTES; k++) begin
      dec_bytes[(WIN_BYTES-1-k)*8 +: 8] = buffer[rd_ptr + PTR_W'(k)];
    end
  end

  assign dec_valid = occupancy >= OCC_W'(WIN_BYTES);

`ifdef FETCH_QUEUE_STATS_EN
  logic [31:0] lines_cnt;
  logic [31:0] starve_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lines_cnt  <= '0;
      starve_cnt <= '0;
    end else if (redirect_valid) begin
      lines_cnt  <= '0;
      starve_cnt <= '0;
    end else begin
      if (fill_accept && lines_cnt != '1) lines_cnt <= lines_cnt + 32'd1;
      if (!dec_valid && state != START && starve_cnt != '1) starve_cnt <= starve_cnt + 32'd1;
    end
  end

  assign stat_lines  = lines_cnt;
  assign stat_starve = starve_cnt;
`else
  assign stat_lines  = '0;
  assign stat_starve = '0;
`endif

  consume_legal: assert property (@(posedge clk) disable iff (!reset_n)
    OCC_W'(dec_consume) <= occupancy)
    else $fatal(1, "fetch_queue: dec_consume exceeds occupancy");

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: fills, skip, wrap streaming, redirect, fill+consume, mid-fill reset.
module tb_fetch_queue;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [63:0]  entry;
  logic         redirect_valid;
  logic [63:0]  redirect_rip;
  logic         ic_req;
  logic [63:0]  ic_addr;
  logic [511:0] ic_rdata;
  logic         ic_done;
  logic         dec_valid;
  logic [119:0] dec_bytes;
  logic [63:0]  dec_rip;
  logic [3:0]   dec_consume;
  logic [31:0]  stat_lines;
  logic [31:0]  stat_starve;

  int passed = 0;
  int total  = 0;

`ifdef FETCH_QUEUE_STATS_EN
  localparam logic [31:0] LINES_AFTER_ONE = 32'd1;
`else
  localparam logic [31:0] LINES_AFTER_ONE = 32'd0;
`endif

  fetch_queue dut (
    .clk(clk), .reset_n(reset_n), .entry(entry),
    .redirect_valid(redirect_valid), .redirect_rip(redirect_rip),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_rdata(ic_rdata), .ic_done(ic_done),
    .dec_valid(dec_valid), .dec_bytes(dec_bytes), .dec_rip(dec_rip),
    .dec_consume(dec_consume), .stat_lines(stat_lines), .stat_starve(stat_starve)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] mk_line(input logic [7:0] base);
    logic [511:0] l;
    for (int i = 0; i < 64; i++) l[i*8 +: 8] = base + 8'(i);
    return l;
  endfunction

  function automatic logic [7:0] win_byte(input int k);
    return dec_bytes[(14-k)*8 +: 8];
  endfunction

  task automatic do_reset(input logic [63:0] e);
    reset_n        = 1'b0;
    entry          = e;
    redirect_valid = 1'b0;
    redirect_rip   = '0;
    ic_rdata       = '0;
    ic_done        = 1'b0;
    dec_consume    = '0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!ic_req && n < 50) begin
      tick();
      n++;
    end
    total++;
    if (ic_req !== 1'b1) $display("FAIL %s: ic_req=%b, required 1 within 50 cycles", name, ic_req);
    else passed++;
  endtask

  // Waits for a request, answers after delay cycles, and returns the requested address.
  task automatic fill(input logic [7:0] base, input int delay, output logic [63:0] addr);
    wait_req("fill_req");
    addr = ic_addr;
    repeat (delay) tick();
    ic_rdata = mk_line(base);
    ic_done  = 1'b1;
    tick();
    ic_done  = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(64'h1000);
    reset_n = 1'b0;
    tick();
    total++;
    if (ic_req !== 1'b0 || ic_addr !== 64'h0 || dec_valid !== 1'b0 || dec_rip !== 64'h0)
      $display("FAIL reset_outputs: req=%b addr=%h valid=%b rip=%h, required 0/0/0/0",
               ic_req, ic_addr, dec_valid, dec_rip);
    else passed++;
    total++;
    if (dut.occupancy !== 8'd0 || dut.rd_ptr !== 7'd0 || dut.wr_ptr !== 7'd0 || stat_lines !== 32'd0)
      $display("FAIL reset_state: occ=%0d rd=%0d wr=%0d lines=%0d, required all 0",
               dut.occupancy, dut.rd_ptr, dut.wr_ptr, stat_lines);
    else passed++;
  endtask

  task automatic test_aligned_fill();
    logic [63:0] a;
    do_reset(64'h1000);
    fill(8'h00, 2, a);
    total++;
    if (a !== 64'h1000) $display("FAIL aligned_addr: got %h, required 1000", a);
    else passed++;
    total++;
    if (dut.occupancy !== 8'd64 || dec_valid !== 1'b1)
      $display("FAIL aligned_occ: occ=%0d valid=%b, required 64/1", dut.occupancy, dec_valid);
    else passed++;
    total++;
    if (win_byte(0) !== 8'h00 || win_byte(14) !== 8'h0E || dec_rip !== 64'h1000)
      $display("FAIL aligned_window: b0=%h b14=%h rip=%h, required 00/0e/1000",
               win_byte(0), win_byte(14), dec_rip);
    else passed++;
    total++;
    if (stat_lines !== LINES_AFTER_ONE)
      $display("FAIL stat_lines: got %0d, required %0d", stat_lines, LINES_AFTER_ONE);
    else passed++;
    tick();
    total++;
    if (ic_req !== 1'b1 || ic_addr !== 64'h1040)
      $display("FAIL second_req: req=%b addr=%h, required 1/1040", ic_req, ic_addr);
    else passed++;
  endtask

  task automatic test_skip_fill();
    logic [63:0] a;
    do_reset(64'h1038);
    fill(8'h00, 1, a);
    total++;
    if (a !== 64'h1000 || dut.occupancy !== 8'd8 || dec_valid !== 1'b0 || dec_rip !== 64'h1038)
      $display("FAIL skip_first: addr=%h occ=%0d valid=%b rip=%h, required 1000/8/0/1038",
               a, dut.occupancy, dec_valid, dec_rip);
    else passed++;
    fill(8'h80, 1, a);
    total++;
    if (a !== 64'h1040 || dut.occupancy !== 8'd72 || dec_valid !== 1'b1)
      $display("FAIL skip_second: addr=%h occ=%0d valid=%b, required 1040/72/1",
               a, dut.occupancy, dec_valid);
    else passed++;
    total++;
    if (win_byte(0) !== 8'h38 || win_byte(7) !== 8'h3F || win_byte(8) !== 8'h80)
      $display("FAIL skip_window: b0=%h b7=%h b8=%h, required 38/3f/80",
               win_byte(0), win_byte(7), win_byte(8));
    else passed++;
  endtask

  task automatic test_wrap_stream();
    logic [7:0]  q[$];
    logic [63:0] rip       = 64'h3000;
    logic [63:0] next_line = 64'h3000;
    logic [7:0]  line_base = 8'h00;
    int          req_cnt   = 0;
    int          consumed  = 0;
    int          n;
    logic        fire;
    logic        ok;
    do_reset(64'h3000);
    for (int cyc = 0; cyc < 90; cyc++) begin
      total++;
      if (dec_valid !== (q.size() >= 15))
        $display("FAIL stream_valid c%0d: got %b, model holds %0d bytes", cyc, dec_valid, q.size());
      else passed++;
      if (q.size() >= 15) begin
        ok = 1'b1;
        for (int k = 0; k < 15; k++) if (win_byte(k) !== q[k]) ok = 1'b0;
        total++;
        if (!ok || dec_rip !== rip)
          $display("FAIL stream_window c%0d: b0=%h rip=%h, required b0=%h rip=%h",
                   cyc, win_byte(0), dec_rip, q[0], rip);
        else passed++;
      end
      n = (q.size() >= 15) ? 15 : 0;
      dec_consume = 4'(n);
      fire = 1'b0;
      if (ic_req) begin
        req_cnt++;
        if (req_cnt == 3) begin
          fire    = 1'b1;
          req_cnt = 0;
          total++;
          if (ic_addr !== next_line)
            $display("FAIL stream_addr c%0d: got %h, required %h", cyc, ic_addr, next_line);
          else passed++;
        end
      end
      ic_done  = fire;
      ic_rdata = mk_line(line_base);
      tick();
      for (int i = 0; i < n; i++) void'(q.pop_front());
      rip      += 64'(n);
      consumed += n;
      if (fire) begin
        for (int i = 0; i < 64; i++) q.push_back(line_base + 8'(i));
        next_line += 64'd64;
        line_base += 8'h40;
      end
    end
    dec_consume = '0;
    ic_done     = 1'b0;
    total++;
    if (dec_rip !== 64'h3000 + 64'(consumed) || consumed < 256)
      $display("FAIL stream_rip: got %h, required %h (consumed %0d)",
               dec_rip, 64'h3000 + 64'(consumed), consumed);
    else passed++;
  endtask

  task automatic test_redirect_drop();
    logic [63:0] a;
    do_reset(64'h1000);
    wait_req("redirect_req");
    redirect_valid = 1'b1;
    redirect_rip   = 64'h2005;
    tick();
    redirect_valid = 1'b0;
    total++;
    if (dut.occupancy !== 8'd0 || dec_rip !== 64'h2005 || ic_req !== 1'b1 || ic_addr !== 64'h1000)
      $display("FAIL redirect_hold: occ=%0d rip=%h req=%b addr=%h, required 0/2005/1/1000",
               dut.occupancy, dec_rip, ic_req, ic_addr);
    else passed++;
    ic_rdata = mk_line(8'h00);
    ic_done  = 1'b1;
    tick();
    ic_done  = 1'b0;
    total++;
    if (dut.occupancy !== 8'd0 || ic_req !== 1'b0 || dec_valid !== 1'b0)
      $display("FAIL redirect_drop: occ=%0d req=%b valid=%b, required 0/0/0",
               dut.occupancy, ic_req, dec_valid);
    else passed++;
    fill(8'h80, 1, a);
    total++;
    if (a !== 64'h2000 || dut.occupancy !== 8'd59 || win_byte(0) !== 8'h85 || dec_rip !== 64'h2005)
      $display("FAIL redirect_refill: addr=%h occ=%0d b0=%h rip=%h, required 2000/59/85/2005",
               a, dut.occupancy, win_byte(0), dec_rip);
    else passed++;
  endtask

  task automatic test_fill_and_consume();
    logic [63:0] a;
    do_reset(64'h1000);
    fill(8'h00, 1, a);
    dec_consume = 4'd15; tick();
    dec_consume = 4'd15; tick();
    dec_consume = 4'd14; tick();
    dec_consume = 4'd0;
    total++;
    if (dut.occupancy !== 8'd20 || ic_req !== 1'b1)
      $display("FAIL pre_overlap: occ=%0d req=%b, required 20/1", dut.occupancy, ic_req);
    else passed++;
    dec_consume = 4'd4;
    ic_rdata    = mk_line(8'h40);
    ic_done     = 1'b1;
    tick();
    dec_consume = 4'd0;
    ic_done     = 1'b0;
    total++;
    if (dut.occupancy !== 8'd80 || dut.rd_ptr !== 7'd48 || dec_rip !== 64'h1030)
      $display("FAIL overlap_occ: occ=%0d rd=%0d rip=%h, required 80/48/1030",
               dut.occupancy, dut.rd_ptr, dec_rip);
    else passed++;
    total++;
    if (win_byte(0) !== 8'h30 || win_byte(14) !== 8'h3E)
      $display("FAIL overlap_window: b0=%h b14=%h, required 30/3e", win_byte(0), win_byte(14));
    else passed++;
  endtask

  task automatic test_reset_mid_fill();
    do_reset(64'h1000);
    wait_req("midreset_req");
    reset_n = 1'b0;
    #1;
    total++;
    if (ic_req !== 1'b0 || ic_addr !== 64'h0 || dut.occupancy !== 8'd0 || dec_rip !== 64'h0)
      $display("FAIL midreset_async: req=%b addr=%h occ=%0d rip=%h, required 0/0/0/0",
               ic_req, ic_addr, dut.occupancy, dec_rip);
    else passed++;
    entry = 64'h5000;
    tick();
    reset_n  = 1'b1;
    ic_rdata = mk_line(8'h11);
    ic_done  = 1'b1;
    tick();
    ic_done  = 1'b0;
    total++;
    if (dut.occupancy !== 8'd0 || ic_req !== 1'b0 || dec_rip !== 64'h5000)
      $display("FAIL midreset_late_done: occ=%0d req=%b rip=%h, required 0/0/5000",
               dut.occupancy, ic_req, dec_rip);
    else passed++;
    tick();
    total++;
    if (ic_req !== 1'b1 || ic_addr !== 64'h5000)
      $display("FAIL midreset_restart: req=%b addr=%h, required 1/5000", ic_req, ic_addr);
    else passed++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_aligned_fill();
    test_skip_fill();
    test_wrap_stream();
    test_redirect_drop();
    test_fill_and_consume();
    test_reset_mid_fill();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
